// File: rtl/uart_alu_ctrl_pkg.sv
// Shared widths, FSM state encoding and ALU opcode constants for the UART ALU controller.
// Pure definitions: no logic, no latency, no flow control.
package uart_alu_ctrl_pkg;

  localparam int NB_DATA_DEF = 8;
  localparam int NB_OP_DEF   = 6;

  typedef enum logic [2:0] {
    GET_A   = 3'd0,
    GET_B   = 3'd1,
    GET_OP  = 3'd2,
    EXEC    = 3'd3,
    WAIT_TX = 3'd4
  } state_t;

  localparam logic [NB_OP_DEF-1:0] OP_ADD = 6'b100000;
  localparam logic [NB_OP_DEF-1:0] OP_SUB = 6'b100010;
  localparam logic [NB_OP_DEF-1:0] OP_AND = 6'b100100;
  localparam logic [NB_OP_DEF-1:0] OP_OR  = 6'b100101;
  localparam logic [NB_OP_DEF-1:0] OP_XOR = 6'b100110;
  localparam logic [NB_OP_DEF-1:0] OP_NOR = 6'b100111;
  localparam logic [NB_OP_DEF-1:0] OP_SRA = 6'b000011;
  localparam logic [NB_OP_DEF-1:0] OP_SRL = 6'b000010;

endpackage

// File: rtl/uart_alu_ctrl_if.sv
// Bundle between the UART rx/tx pair, the external ALU and the frame controller.
// slave = controller side, master = UART/ALU environment side; no backpressure, ticks only.
interface uart_alu_ctrl_if
  import uart_alu_ctrl_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_OP   = NB_OP_DEF
);

  logic               rx_done_tick;
  logic [NB_DATA-1:0] rx_data;
  logic               tx_done_tick;
  logic [NB_DATA-1:0] alu_result;
  logic [NB_DATA-1:0] alu_a;
  logic [NB_DATA-1:0] alu_b;
  logic [NB_OP-1:0]   alu_op;
  logic               tx_start;
  logic [NB_DATA-1:0] tx_data;
  logic               busy;
  logic               ovr;
  logic               tmo;

  modport slave (
    input  rx_done_tick, rx_data, tx_done_tick, alu_result,
    output alu_a, alu_b, alu_op, tx_start, tx_data, busy, ovr, tmo
  );

  modport master (
    output rx_done_tick, rx_data, tx_done_tick, alu_result,
    input  alu_a, alu_b, alu_op, tx_start, tx_data, busy, ovr, tmo
  );

endinterface

// File: rtl/uart_alu_ctrl_frame_timer.sv
// Idle-cycle counter for a partially received frame; expire is combinational in the last idle cycle.
// Clear wins over enable; the count never wraps, it restarts from zero on expiry.
module frame_timer #(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  // Flag the idle cycle whose increment would bring the count to TIMEOUT_CYC-1.
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 2);

  logic [CW-1:0] cnt;

  assign expire = enable && (cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear || expire) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_alu_ctrl.sv
// Collects A, B, OP bytes from the UART, drives the ALU, and sends the result back.
// tx_start two cycles after the opcode tick; bytes arriving while a result is in flight are dropped (ovr).
module uart_alu_ctrl
  import uart_alu_ctrl_pkg::*;
#(
  parameter int NB_DATA     = NB_DATA_DEF,
  parameter int NB_OP       = NB_OP_DEF,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic              clk,
  input  logic              reset,
  uart_alu_ctrl_if.slave    bus
);

  state_t state, next_state;

  logic rx_tick, tx_tick;
  logic in_frame;
  logic tmr_clear, tmr_enable, tmr_expire;
  logic ld_a, ld_b, ld_op, ld_tx, drop;
  logic busy_c, tmo_c;

  logic [NB_DATA-1:0] alu_a_q, alu_b_q, tx_data_q;
  logic [NB_OP-1:0]   alu_op_q;
  logic               tx_start_q, ovr_q;

  assign rx_tick = bus.rx_done_tick;
  assign tx_tick = bus.tx_done_tick;

  // The timer only runs between the first and last byte of a frame; everywhere else it is held at zero.
  assign in_frame   = (state == GET_B) || (state == GET_OP);
  assign tmr_enable = in_frame && !rx_tick;
  assign tmr_clear  = rx_tick || !in_frame;

  frame_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_frame_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (tmr_clear),
    .enable (tmr_enable),
    .expire (tmr_expire)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= GET_A;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      GET_A: begin
        if (rx_tick) next_state = GET_B;
      end
      GET_B: begin
        if (rx_tick)         next_state = GET_OP;
        else if (tmr_expire) next_state = GET_A;
      end
      GET_OP: begin
        if (rx_tick)         next_state = EXEC;
        else if (tmr_expire) next_state = GET_A;
      end
      EXEC: begin
        next_state = WAIT_TX;
      end
      WAIT_TX: begin
        if (tx_tick) next_state = GET_A;
      end
      default: begin
        next_state = GET_A;
      end
    endcase
  end

  always_comb begin
    busy_c = (state != GET_A);
    ld_a   = (state == GET_A)  && rx_tick;
    ld_b   = (state == GET_B)  && rx_tick;
    ld_op  = (state == GET_OP) && rx_tick;
    ld_tx  = (state == EXEC);
    drop   = rx_tick && ((state == EXEC) || (state == WAIT_TX));
    tmo_c  = tmr_expire;
  end

  // Operand registers only change on their own byte, so a new A leaves the previous B and OP intact.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      if (ld_a)  alu_a_q   <= bus.rx_data;
      if (ld_b)  alu_b_q   <= bus.rx_data;
      if (ld_op) alu_op_q  <= bus.rx_data[NB_OP-1:0];
      if (ld_tx) tx_data_q <= bus.alu_result;
      tx_start_q <= ld_tx;
      if (drop)  ovr_q     <= 1'b1;
    end
  end

  assign bus.alu_a    = alu_a_q;
  assign bus.alu_b    = alu_b_q;
  assign bus.alu_op   = alu_op_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_start = tx_start_q;
  assign bus.ovr      = ovr_q;
  assign bus.busy     = busy_c;
  assign bus.tmo      = tmo_c;

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Scoreboarded bench for uart_alu_ctrl with a behavioural ALU on alu_result.
module tb_uart_alu_ctrl;
  import uart_alu_ctrl_pkg::*;

  localparam int NB_DATA     = 8;
  localparam int NB_OP       = 6;
  localparam int TIMEOUT_CYC = 20;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  uart_alu_ctrl_if #(.NB_DATA(NB_DATA), .NB_OP(NB_OP)) bus ();

  uart_alu_ctrl #(
    .NB_DATA     (NB_DATA),
    .NB_OP       (NB_OP),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always_comb begin
    case (bus.alu_op)
      OP_ADD:  bus.alu_result = bus.alu_a + bus.alu_b;
      OP_SUB:  bus.alu_result = bus.alu_a - bus.alu_b;
      OP_AND:  bus.alu_result = bus.alu_a & bus.alu_b;
      OP_OR:   bus.alu_result = bus.alu_a | bus.alu_b;
      OP_XOR:  bus.alu_result = bus.alu_a ^ bus.alu_b;
      OP_NOR:  bus.alu_result = ~(bus.alu_a | bus.alu_b);
      OP_SRL:  bus.alu_result = bus.alu_a >> bus.alu_b[2:0];
      OP_SRA:  bus.alu_result = NB_DATA'($signed(bus.alu_a) >>> bus.alu_b[2:0]);
      default: bus.alu_result = '0;
    endcase
  end

  int n_checks = 0;
  int n_errors = 0;
  int n_tx     = 0;
  logic [NB_DATA-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Every transmit request must consume one queued result.
  always @(posedge clk) begin
    #2;
    if (reset && bus.tx_start === 1'b1) begin
      n_tx++;
      if (exp_q.size() == 0) check("tx_spurious", bus.tx_start, 1'b0);
      else                   check("tx_data_sb", bus.tx_data, exp_q.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [NB_DATA-1:0] b);
    bus.rx_data      = b;
    bus.rx_done_tick = 1'b1;
    step();
    bus.rx_done_tick = 1'b0;
  endtask

  task automatic done_tx();
    bus.tx_done_tick = 1'b1;
    step();
    bus.tx_done_tick = 1'b0;
  endtask

  task automatic frame(input logic [7:0] a, input logic [7:0] b,
                       input logic [5:0] op, input logic [7:0] res);
    send(a);
    check("alu_a", bus.alu_a, a);
    send(b);
    check("alu_b", bus.alu_b, b);
    exp_q.push_back(res);
    send({2'b00, op});
    check("alu_op", bus.alu_op, op);
    check("tx_start_n1", bus.tx_start, 1'b0);
    step();
    check("tx_start_n2", bus.tx_start, 1'b1);
    check("tx_data", bus.tx_data, res);
    step();
    check("tx_start_n3", bus.tx_start, 1'b0);
    check("busy_wait_tx", bus.busy, 1'b1);
  endtask

  initial begin
    bus.rx_done_tick = 1'b0;
    bus.rx_data      = '0;
    bus.tx_done_tick = 1'b0;
    step();
    step();
    check("rst_alu_a",    bus.alu_a, 0);
    check("rst_alu_b",    bus.alu_b, 0);
    check("rst_alu_op",   bus.alu_op, 0);
    check("rst_tx_data",  bus.tx_data, 0);
    check("rst_tx_start", bus.tx_start, 0);
    check("rst_busy",     bus.busy, 0);
    check("rst_ovr",      bus.ovr, 0);
    check("rst_tmo",      bus.tmo, 0);
    reset = 1'b1;
    step();

    frame(8'h05, 8'h03, OP_ADD, 8'h08);

    // Byte arriving while the result is still being transmitted.
    send(8'h77);
    check("ovr_set",      bus.ovr, 1'b1);
    check("ovr_alu_a",    bus.alu_a, 8'h05);
    check("ovr_busy",     bus.busy, 1'b1);
    repeat (3) step();
    check("hold_wait_tx", bus.busy, 1'b1);
    done_tx();
    check("busy_idle",    bus.busy, 1'b0);

    frame(8'hFF, 8'h01, OP_SUB, 8'hFE);
    done_tx();
    check("busy_idle2",   bus.busy, 1'b0);
    check("ovr_sticky",   bus.ovr, 1'b1);

    // Partial frame abandoned after TIMEOUT_CYC-1 idle cycles.
    send(8'h10);
    for (int i = 1; i <= 20; i++) begin
      check("tmo_idle", bus.tmo, (i == 19));
      if (i == 19) check("busy_pre_tmo", bus.busy, 1'b1);
      if (i == 20) check("busy_post_tmo", bus.busy, 1'b0);
      step();
    end
    send(8'h33);
    check("alu_a_after_tmo", bus.alu_a, 8'h33);
    check("alu_b_kept",      bus.alu_b, 8'h01);

    // tx_done_tick in GET_B must be ignored.
    done_tx();
    check("txdone_getb_busy",  bus.busy, 1'b1);
    check("txdone_getb_start", bus.tx_start, 1'b0);
    send(8'h04);
    check("alu_b_after_ign",   bus.alu_b, 8'h04);
    check("alu_a_after_ign",   bus.alu_a, 8'h33);
    exp_q.push_back(8'h37);
    send({2'b00, OP_ADD});
    step();
    check("tx_data3", bus.tx_data, 8'h37);
    step();

    // Simultaneous rx and tx done in WAIT_TX: return idle, byte dropped.
    bus.rx_data      = 8'h55;
    bus.rx_done_tick = 1'b1;
    bus.tx_done_tick = 1'b1;
    step();
    bus.rx_done_tick = 1'b0;
    bus.tx_done_tick = 1'b0;
    check("simul_busy",  bus.busy, 1'b0);
    check("simul_ovr",   bus.ovr, 1'b1);
    check("simul_alu_a", bus.alu_a, 8'h33);

    // Reset in GET_OP discards the frame.
    send(8'h01);
    send(8'h02);
    check("pre_rst_busy", bus.busy, 1'b1);
    reset = 1'b0;
    #1;
    check("mid_rst_alu_a",    bus.alu_a, 0);
    check("mid_rst_alu_b",    bus.alu_b, 0);
    check("mid_rst_alu_op",   bus.alu_op, 0);
    check("mid_rst_tx_data",  bus.tx_data, 0);
    check("mid_rst_tx_start", bus.tx_start, 0);
    check("mid_rst_busy",     bus.busy, 0);
    check("mid_rst_ovr",      bus.ovr, 0);
    check("mid_rst_tmo",      bus.tmo, 0);
    repeat (3) step();
    reset = 1'b1;
    repeat (10) step();
    check("post_rst_busy", bus.busy, 1'b0);

    frame(8'h09, 8'h02, OP_SUB, 8'h07);
    done_tx();
    repeat (3) step();

    check("queue_drained", exp_q.size(), 0);
    check("tx_count",      n_tx, 4);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
